// File: rtl/alu_issue_ctrl.sv
// Sequential issuer for the 4-bit combinational ALU: decodes 9-bit instructions,
// reads a 4-entry register file, drives the ALU, writes back and returns a response.
`timescale 1ns/1ps
module alu_issue_ctrl #(
    parameter int unsigned DW   = 4,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    input  logic [8:0]      instr_i,
    output logic            instr_ready_o,
    output logic [DW-1:0]   alu_a_o,
    output logic [DW-1:0]   alu_b_o,
    output logic [2:0]      alu_op_o,
    input  logic [DW-1:0]   alu_result_i,
    output logic            res_valid_o,
    output logic [DW-1:0]   res_data_o,
    output logic            res_zero_o,
    output logic            res_err_o,
    input  logic            res_ready_i,
    output logic [CNTW-1:0] ops_count_o
);

    localparam int unsigned NREG = 4;
    localparam int unsigned RW   = 2;
    localparam int unsigned OPW  = 3;
    localparam logic [OPW-1:0] OP_LDI = 3'd5;
    localparam logic [OPW-1:0] OP_NOP = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [RW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_data_q, res_data_d;
    logic            res_zero_q, res_zero_d;
    logic            res_err_q, res_err_d;
    logic [CNTW-1:0] ops_count_q, ops_count_d;

    logic [OPW-1:0] op_in;
    logic [RW-1:0]  rd_in, rs1_in, rs2_in;
    logic [DW-1:0]  imm_in;
    logic           accept;

    assign op_in  = instr_i[8:6];
    assign rd_in  = instr_i[5:4];
    assign rs1_in = instr_i[3:2];
    assign rs2_in = instr_i[1:0];
    assign imm_in = DW'({rs1_in, rs2_in});

    // Ready drops combinationally with rst so nothing is accepted while in reset.
    assign instr_ready_o = (state_q == IDLE) && !rst_i;
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (op_in < OP_LDI) ? ISSUE : RESP;
            ISSUE:   state_d = RESP;
            RESP:    if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d      = regs_q;
        rd_d        = rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_err_d   = res_err_q;
        ops_count_d = ops_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d = rd_in;
                    if (op_in < OP_LDI) begin
                        alu_a_d  = regs_q[rs1_in];
                        alu_b_d  = regs_q[rs2_in];
                        alu_op_d = op_in;
                    end else begin
                        // LDI, NOP and illegal respond directly without the ALU
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b0;
                        res_data_d  = '0;
                        res_zero_d  = 1'b1;
                        if (op_in == OP_LDI) begin
                            regs_d[rd_in] = imm_in;
                            res_data_d    = imm_in;
                            res_zero_d    = (imm_in == '0);
                        end else if (op_in != OP_NOP) begin
                            res_err_d = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                regs_d[rd_q] = alu_result_i;
                res_data_d   = alu_result_i;
                res_zero_d   = (alu_result_i == '0);
                res_err_d    = 1'b0;
                res_valid_d  = 1'b1;
            end
            RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    ops_count_d = ops_count_q + CNTW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q      <= '{default: '0};
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
            ops_count_q <= '0;
        end else begin
            regs_q      <= regs_d;
            rd_q        <= rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_err_q   <= res_err_d;
            ops_count_q <= ops_count_d;
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_zero_o  = res_zero_q;
    assign res_err_o   = res_err_q;
    assign ops_count_o = ops_count_q;

endmodule
